playback_controller: RTL and testbench
======================================

PLAYBACK_CONTROLLER -- requirements
Module: playback_controller

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL provide parameter DIV_DEFAULT, default 16'd1136, giving the sample-strobe period in clk cycles after reset or speed_reset.
REQ-002 The block SHALL provide parameter DIV_MIN, default 16'd64, the smallest allowed divisor.
REQ-003 The block SHALL provide parameter DIV_MAX, default 16'd8192, the largest allowed divisor.
REQ-004 The block SHALL provide parameter DIV_STEP, default 16'd64, the divisor change per speed command.
REQ-005 The block SHALL provide parameter ADDR_START, default 22'h000000, the first word address of the audio region.
REQ-006 The block SHALL provide parameter ADDR_END, default 22'h07FFFF, the last word address of the audio region (inclusive).

Ports (name, direction, width, meaning):
REQ-007 clk  input  1  single system clock; all state changes on its rising edge.
REQ-008 reset  input  1  synchronous, active-high reset.
REQ-009 cmd_play  input  1  one-cycle pulse; start playback.
REQ-010 cmd_pause  input  1  one-cycle pulse; pause playback.
REQ-011 cmd_forward  input  1  one-cycle pulse; select forward direction.
REQ-012 cmd_backward  input  1  one-cycle pulse; select backward direction.
REQ-013 cmd_restart  input  1  one-cycle pulse; jump to the start of the region for the current direction.
REQ-014 speed_up  input  1  one-cycle pulse; decrease the divisor.
REQ-015 speed_down  input  1  one-cycle pulse; increase the divisor.
REQ-016 speed_reset  input  1  one-cycle pulse; restore DIV_DEFAULT.
REQ-017 inc  input  1  one-cycle pulse from the flash reader; current word consumed.
REQ-018 samplenow  output  1  registered one-cycle sample strobe to the flash reader.
REQ-019 word_addr  output  22  flash word address for the flash reader.
REQ-020 playing  output  1  1 = PLAYING state.
REQ-021 forward  output  1  1 = forward direction, 0 = backward.
REQ-022 divisor  output  16  current strobe period.

Function
REQ-023 State machine SHALL have two states, PAUSED and PLAYING: cmd_play moves PAUSED->PLAYING, cmd_pause moves PLAYING->PAUSED, and cmd_play with cmd_pause in the same cycle SHALL yield PAUSED.
REQ-024 In PLAYING, the counter SHALL count 0..divisor-1 and, on the cycle it equals divisor-1, wrap to 0 and assert samplenow on the next cycle for exactly one cycle, giving one strobe every divisor cycles.
REQ-025 In PAUSED, the counter SHALL be held at 0 and samplenow SHALL be 0; the first strobe after entering PLAYING SHALL occur divisor cycles after the transition.
REQ-026 speed_reset SHALL set divisor to DIV_DEFAULT, with priority over speed_up and speed_down.
REQ-027 speed_up SHALL set divisor to max(divisor-DIV_STEP, DIV_MIN), saturating with no underflow.
REQ-028 speed_down SHALL set divisor to min(divisor+DIV_STEP, DIV_MAX), using 17-bit intermediate arithmetic with no overflow.
REQ-029 speed_up and speed_down together without speed_reset SHALL leave divisor unchanged.
REQ-030 If the counter is >= new divisor-1 after a divisor change, the counter SHALL reset to 0 on the next cycle with no strobe from that event.
REQ-031 cmd_forward SHALL set forward=1 and cmd_backward SHALL set forward=0; both in the same cycle SHALL leave forward unchanged.
REQ-032 On inc with forward=1, word_addr SHALL become word_addr+1, or ADDR_START when word_addr==ADDR_END.
REQ-033 On inc with forward=0, word_addr SHALL become word_addr-1, or ADDR_END when word_addr==ADDR_START.
REQ-034 word_addr SHALL update on the cycle after inc (1-cycle latency).
REQ-035 inc SHALL be honored in PAUSED so that an in-flight reader transaction completes.
REQ-036 cmd_restart SHALL load ADDR_START if the post-update direction is forward, else ADDR_END, with priority over a simultaneous inc.
REQ-037 cmd_restart SHALL NOT change the play state, the divisor or the counter.

Reset
REQ-038 With reset high at a clk edge, outputs SHALL be samplenow=0, word_addr=ADDR_START, playing=0, forward=1, divisor=DIV_DEFAULT, and the counter SHALL be 0.
REQ-039 reset SHALL override all commands in the same cycle.
REQ-040 reset asserted mid-count SHALL discard any pending strobe.

Verification
REQ-041 After reset, cmd_play; samplenow pulses at 1136, 2272 and 3408 cycles after the play cycle, each one cycle wide -> required.
REQ-042 word_addr=22'h07FFFF, forward=1, inc -> word_addr=22'h000000; then cmd_backward and inc -> word_addr=22'h07FFFF.
REQ-043 16 speed_up pulses from 1136 -> divisor 112 then 64, held at 64; 200 speed_down pulses -> held at 8192; speed_reset with speed_up in the same cycle -> 1136.
REQ-044 word_addr=22'h000100, forward=1, cmd_restart and inc in the same cycle -> 22'h000000; cmd_backward with cmd_restart -> 22'h07FFFF.
REQ-045 PLAYING, counter at 500, cmd_pause -> no samplenow while paused; cmd_play and cmd_pause in the same cycle -> PAUSED; inc while paused -> address advances.
REQ-046 PLAYING, counter at 1000, speed_up x8 (divisor 624) -> counter resets to 0 with no strobe, next strobe 624 cycles later; reset mid-count -> all outputs at reset values on the next cycle.

Source files
------------

// File: rtl/playback_controller.sv
// playback_controller: play/pause FSM, sample-strobe divider with speed control, and flash word-address stepping.
module playback_controller #(
  parameter logic [15:0] DIV_DEFAULT = 16'd1136,
  parameter logic [15:0] DIV_MIN     = 16'd64,
  parameter logic [15:0] DIV_MAX     = 16'd8192,
  parameter logic [15:0] DIV_STEP    = 16'd64,
  parameter logic [21:0] ADDR_START  = 22'h000000,
  parameter logic [21:0] ADDR_END    = 22'h07FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_play,
  input  logic        cmd_pause,
  input  logic        cmd_forward,
  input  logic        cmd_backward,
  input  logic        cmd_restart,
  input  logic        speed_up,
  input  logic        speed_down,
  input  logic        speed_reset,
  input  logic        inc,
  output logic        samplenow,
  output logic [21:0] word_addr,
  output logic        playing,
  output logic        forward,
  output logic [15:0] divisor
);
  typedef enum logic {PAUSED, PLAYING} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d, div_q, div_d, div_slow, div_fast;
  logic [16:0] div_sum;
  logic [21:0] addr_q, addr_d;
  logic fwd_q, fwd_d, smp_q, smp_d, chg_q, chg_d, wrap;
  always_comb begin
    state_d  = cmd_pause ? PAUSED : cmd_play ? PLAYING : state_q;
    div_sum  = {1'b0, div_q} + {1'b0, DIV_STEP};
    div_slow = div_sum > {1'b0, DIV_MAX} ? DIV_MAX : div_sum[15:0];
    div_fast = {1'b0, div_q} < ({1'b0, DIV_MIN} + {1'b0, DIV_STEP}) ? DIV_MIN : div_q - DIV_STEP;
    div_d    = speed_reset ? DIV_DEFAULT :
               (speed_up & ~speed_down) ? div_fast :
               (speed_down & ~speed_up) ? div_slow : div_q;
    chg_d    = div_d != div_q;
    // A wrap forced by a just-shrunk divisor restarts the period silently.
    wrap     = (state_q == PLAYING) && (cnt_q >= div_q - 16'd1);
    smp_d    = wrap & ~chg_q;
    cnt_d    = (state_q == PAUSED || wrap) ? 16'd0 : cnt_q + 16'd1;
    fwd_d    = (cmd_forward & ~cmd_backward) ? 1'b1 : (cmd_backward & ~cmd_forward) ? 1'b0 : fwd_q;
    addr_d   = cmd_restart ? (fwd_d ? ADDR_START : ADDR_END) :
               !inc ? addr_q :
               fwd_q ? (addr_q == ADDR_END ? ADDR_START : addr_q + 22'd1) :
                       (addr_q == ADDR_START ? ADDR_END : addr_q - 22'd1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= PAUSED;
      cnt_q   <= '0;
      div_q   <= DIV_DEFAULT;
      addr_q  <= ADDR_START;
      fwd_q   <= 1'b1;
      smp_q   <= 1'b0;
      chg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      addr_q  <= addr_d;
      fwd_q   <= fwd_d;
      smp_q   <= smp_d;
      chg_q   <= chg_d;
    end
  end
  assign samplenow = smp_q;
  assign word_addr = addr_q;
  assign playing   = state_q == PLAYING;
  assign forward   = fwd_q;
  assign divisor   = div_q;
endmodule

// File: tb/tb_playback_controller.sv
// tb_playback_controller: directed and random stimulus against a cycle-level behavioural model.
module tb_playback_controller;
  localparam int RST = 512, PLAY = 256, PAUSE = 128, FWD = 64, BWD = 32, RESTART = 16;
  localparam int UP = 8, DN = 4, SRST = 2, INC = 1;
  localparam int END_A = 'h7FFFF;
  logic clk = 0, reset = 0, cmd_play = 0, cmd_pause = 0, cmd_forward = 0, cmd_backward = 0;
  logic cmd_restart = 0, speed_up = 0, speed_down = 0, speed_reset = 0, inc = 0;
  logic samplenow, playing, forward;
  logic [21:0] word_addr;
  logic [15:0] divisor;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  int m_cnt, m_div, m_addr;
  bit m_play, m_fwd, m_smp, m_chg;
  int strobes[$];
  playback_controller dut (
    .clk(clk), .reset(reset), .cmd_play(cmd_play), .cmd_pause(cmd_pause),
    .cmd_forward(cmd_forward), .cmd_backward(cmd_backward), .cmd_restart(cmd_restart),
    .speed_up(speed_up), .speed_down(speed_down), .speed_reset(speed_reset), .inc(inc),
    .samplenow(samplenow), .word_addr(word_addr), .playing(playing), .forward(forward),
    .divisor(divisor)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask
  task automatic model_step();
    int n_div;
    bit fire, n_fwd;
    if (reset) begin
      m_play = 0; m_cnt = 0; m_div = 1136; m_addr = 0; m_fwd = 1; m_smp = 0; m_chg = 0;
      return;
    end
    fire  = m_play && (m_cnt >= m_div - 1);
    m_smp = fire && !m_chg;
    m_cnt = (!m_play || fire) ? 0 : m_cnt + 1;
    n_div = m_div;
    if (speed_reset) n_div = 1136;
    else if (speed_up && !speed_down) n_div = (m_div - 64 < 64) ? 64 : m_div - 64;
    else if (speed_down && !speed_up) n_div = (m_div + 64 > 8192) ? 8192 : m_div + 64;
    m_chg = n_div != m_div;
    m_div = n_div;
    if (cmd_pause) m_play = 0;
    else if (cmd_play) m_play = 1;
    n_fwd = (cmd_forward && !cmd_backward) ? 1 : (cmd_backward && !cmd_forward) ? 0 : m_fwd;
    if (cmd_restart) m_addr = n_fwd ? 0 : END_A;
    else if (inc) m_addr = m_fwd ? (m_addr == END_A ? 0 : m_addr + 1) : (m_addr == 0 ? END_A : m_addr - 1);
    m_fwd = n_fwd;
  endtask
  task automatic cyc1(input int v);
    {reset, cmd_play, cmd_pause, cmd_forward, cmd_backward, cmd_restart,
     speed_up, speed_down, speed_reset, inc} = v[9:0];
    @(posedge clk);
    model_step();
    #1;
    cyc++;
    check("samplenow", 32'(samplenow), 32'(m_smp));
    check("word_addr", 32'(word_addr), 32'(m_addr));
    check("playing", 32'(playing), 32'(m_play));
    check("forward", 32'(forward), 32'(m_fwd));
    check("divisor", 32'(divisor), 32'(m_div));
    if (samplenow) strobes.push_back(cyc);
    {reset, cmd_play, cmd_pause, cmd_forward, cmd_backward, cmd_restart,
     speed_up, speed_down, speed_reset, inc} = '0;
  endtask
  initial begin
    int p, a, v;
    cyc1(RST);
    cyc1(RST | PLAY | BWD | UP | INC);
    check("rst_samplenow", 32'(samplenow), 0);
    check("rst_addr", 32'(word_addr), 0);
    check("rst_playing", 32'(playing), 0);
    check("rst_forward", 32'(forward), 1);
    check("rst_divisor", 32'(divisor), 1136);
    strobes.delete();
    cyc1(PLAY);
    p = cyc;
    repeat (3500) cyc1(0);
    check("strobe_count", strobes.size(), 3);
    if (strobes.size() == 3) begin
      check("strobe1", strobes[0], p + 1136);
      check("strobe2", strobes[1], p + 2272);
      check("strobe3", strobes[2], p + 3408);
    end
    cyc1(PAUSE);
    cyc1(BWD);
    cyc1(INC);
    check("wrap_back", 32'(word_addr), END_A);
    cyc1(FWD);
    cyc1(INC);
    check("wrap_fwd", 32'(word_addr), 0);
    cyc1(BWD);
    cyc1(INC);
    check("wrap_back2", 32'(word_addr), END_A);
    cyc1(FWD | RESTART);
    check("restart_fwd", 32'(word_addr), 0);
    repeat (256) cyc1(INC);
    check("addr_100", 32'(word_addr), 'h100);
    cyc1(RESTART | INC);
    check("restart_over_inc", 32'(word_addr), 0);
    cyc1(BWD | RESTART);
    check("restart_back", 32'(word_addr), END_A);
    check("restart_dir", 32'(forward), 0);
    repeat (16) cyc1(UP);
    check("div_16up", 32'(divisor), 112);
    cyc1(UP);
    check("div_min", 32'(divisor), 64);
    cyc1(UP);
    check("div_min_hold", 32'(divisor), 64);
    repeat (200) cyc1(DN);
    check("div_max_hold", 32'(divisor), 8192);
    cyc1(UP | DN);
    check("div_updn", 32'(divisor), 8192);
    cyc1(SRST | UP);
    check("div_srst", 32'(divisor), 1136);
    cyc1(PLAY);
    repeat (500) cyc1(0);
    cyc1(PAUSE);
    strobes.delete();
    repeat (2000) cyc1(0);
    check("paused_strobes", strobes.size(), 0);
    cyc1(PLAY | PAUSE);
    check("play_pause", 32'(playing), 0);
    cyc1(INC);
    check("paused_inc", 32'(word_addr), END_A - 1);
    cyc1(PLAY);
    p = cyc;
    strobes.delete();
    repeat (1000) cyc1(0);
    repeat (8) cyc1(UP);
    check("div_624", 32'(divisor), 624);
    repeat (1300) cyc1(0);
    // divisor 944 at count 1003 forces the silent restart at p+1004
    check("shrink_strobes", strobes.size() >= 2, 1);
    if (strobes.size() >= 2) begin
      check("shrink_first", strobes[0], p + 1628);
      check("shrink_period", strobes[1] - strobes[0], 624);
    end
    repeat (300) cyc1(0);
    cyc1(RST);
    check("mid_rst_samplenow", 32'(samplenow), 0);
    check("mid_rst_addr", 32'(word_addr), 0);
    check("mid_rst_playing", 32'(playing), 0);
    check("mid_rst_forward", 32'(forward), 1);
    check("mid_rst_divisor", 32'(divisor), 1136);
    strobes.delete();
    repeat (1200) cyc1(0);
    check("post_rst_strobes", strobes.size(), 0);
    repeat (20000) begin
      v = 0;
      v |= ($urandom_range(0, 2999) == 0) ? RST : 0;
      v |= ($urandom_range(0, 19) == 0) ? PLAY : 0;
      v |= ($urandom_range(0, 299) == 0) ? PAUSE : 0;
      v |= ($urandom_range(0, 49) == 0) ? FWD : 0;
      v |= ($urandom_range(0, 49) == 0) ? BWD : 0;
      v |= ($urandom_range(0, 199) == 0) ? RESTART : 0;
      v |= ($urandom_range(0, 29) == 0) ? UP : 0;
      v |= ($urandom_range(0, 39) == 0) ? DN : 0;
      v |= ($urandom_range(0, 499) == 0) ? SRST : 0;
      v |= ($urandom_range(0, 3) == 0) ? INC : 0;
      cyc1(v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
